// File: rtl/team_action_pkg.sv
// Shared costs, ship state encoding and direction type for the team action scheduler.
package team_action_pkg;

    localparam int FIRE_COST   = 30;
    localparam int SHIELD_COST = 25;
    localparam int CLOAK_COST  = 15;

    typedef logic [1:0] ship_state_t;

    localparam ship_state_t ST_IDLE     = 2'd0;
    localparam ship_state_t ST_COOLDOWN = 2'd1;
    localparam ship_state_t ST_CLOAK    = 2'd2;
    localparam ship_state_t ST_DEAD     = 2'd3;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_e;

    // Fire needs cost plus reserve; one extra bit so large reserves cannot wrap the compare.
    function automatic logic [8:0] fire_threshold(input int reserve);
        return 9'(FIRE_COST + reserve);
    endfunction

endpackage

// File: rtl/team_rr_fire_arbiter.sv
// Combinational k-of-N round-robin arbiter: grants up to MAX_FIRE requests starting at i_ptr.
module team_rr_fire_arbiter #(
    parameter int NUM_SHIPS = 3,
    parameter int MAX_FIRE  = 2,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_SHIPS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_SHIPS-1:0] o_grant,
    output logic [PTR_W-1:0]     o_next_ptr
);

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin : arb
        int cnt;
        o_grant    = '0;
        o_next_ptr = i_ptr;
        cnt        = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < NUM_SHIPS; j++) begin
                if (((pass == 0) && (j >= int'(i_ptr))) ||
                    ((pass == 1) && (j <  int'(i_ptr)))) begin
                    if (i_req[j] && (cnt < MAX_FIRE)) begin
                        o_grant[j] = 1'b1;
                        cnt        = cnt + 1;
                        o_next_ptr = (j == NUM_SHIPS - 1) ? '0 : PTR_W'(j + 1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/team_action_scheduler.sv
// Per-ship action FSMs (cooldown, cloak hold, energy gating) feeding a round-robin fire arbiter;
// all game-facing outputs are registered.
module team_action_scheduler
    import team_action_pkg::*;
#(
    parameter int NUM_SHIPS     = 3,
    parameter int MAX_FIRE      = 2,
    parameter int FIRE_COOLDOWN = 2,
    parameter int CLOAK_HOLD    = 3,
    parameter int FIRE_RESERVE  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_SHIPS-1:0]   i_fire_req,
    input  logic [2*NUM_SHIPS-1:0] i_fire_dir_req,
    input  logic [NUM_SHIPS-1:0]   i_shield_req,
    input  logic [NUM_SHIPS-1:0]   i_cloak_req,
    input  logic [8*NUM_SHIPS-1:0] i_energy,
    input  logic [NUM_SHIPS-1:0]   i_destroyed,
    output logic [NUM_SHIPS-1:0]   o_attempt_fire,
    output logic [NUM_SHIPS-1:0]   o_attempt_shield,
    output logic [NUM_SHIPS-1:0]   o_attempt_cloak,
    output logic [2*NUM_SHIPS-1:0] o_fire_dir,
    output logic [15:0]            o_fire_count
);

    localparam int          PTR_W       = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1;
    localparam logic [8:0]  FIRE_THRESH = fire_threshold(FIRE_RESERVE);

    ship_state_t            r_state   [NUM_SHIPS];
    logic [7:0]             r_cdCnt   [NUM_SHIPS];
    logic [7:0]             r_holdCnt [NUM_SHIPS];
    logic [PTR_W-1:0]       r_rrPtr;
    logic [NUM_SHIPS-1:0]   r_attemptFire;
    logic [NUM_SHIPS-1:0]   r_attemptShield;
    logic [NUM_SHIPS-1:0]   r_attemptCloak;
    logic [2*NUM_SHIPS-1:0] r_fireDir;
    logic [15:0]            r_fireCount;

    logic [NUM_SHIPS-1:0]   w_alive;
    logic [NUM_SHIPS-1:0]   w_inCloak;
    logic [NUM_SHIPS-1:0]   w_cloakEnergyOk;
    logic [NUM_SHIPS-1:0]   w_shieldGrant;
    logic [NUM_SHIPS-1:0]   w_cloakGrant;
    logic [NUM_SHIPS-1:0]   w_fireElig;
    logic [NUM_SHIPS-1:0]   w_fireGrant;
    logic [NUM_SHIPS-1:0]   w_holdCloak;
    logic [PTR_W-1:0]       w_nextPtr;
    ship_state_t            w_nextState [NUM_SHIPS];
    logic [7:0]             w_nextCd    [NUM_SHIPS];
    logic [7:0]             w_nextHold  [NUM_SHIPS];
    logic [16:0]            w_countSum;

    // Priority shield > cloak > fire; a ship being destroyed this cycle gets nothing.
    for (genvar g = 0; g < NUM_SHIPS; g++) begin : g_ship
        logic [7:0] w_energy;
        assign w_energy           = i_energy[8*g +: 8];
        assign w_alive[g]         = (r_state[g] != ST_DEAD) && !i_destroyed[g];
        assign w_inCloak[g]       = (r_state[g] == ST_CLOAK);
        assign w_cloakEnergyOk[g] = (w_energy >= 8'(CLOAK_COST));
        assign w_shieldGrant[g]   = w_alive[g] && i_shield_req[g] && (w_energy >= 8'(SHIELD_COST));
        assign w_cloakGrant[g]    = w_alive[g] && i_cloak_req[g] && w_cloakEnergyOk[g]
                                    && !w_inCloak[g] && !w_shieldGrant[g];
        assign w_fireElig[g]      = w_alive[g] && i_fire_req[g] && ({1'b0, w_energy} >= FIRE_THRESH)
                                    && (r_state[g] == ST_IDLE) && (r_cdCnt[g] == 8'd0)
                                    && !w_shieldGrant[g] && !w_cloakGrant[g];
    end

    team_rr_fire_arbiter #(
        .NUM_SHIPS (NUM_SHIPS),
        .MAX_FIRE  (MAX_FIRE),
        .PTR_W     (PTR_W)
    ) u_arbiter (
        .i_req      (w_fireElig),
        .i_ptr      (r_rrPtr),
        .o_grant    (w_fireGrant),
        .o_next_ptr (w_nextPtr)
    );

    // The cooldown counter runs independently of the state so it keeps counting through a cloak;
    // fire is only eligible once it has drained, even if an early cloak exit lands in IDLE.
    always_comb begin
        for (int i = 0; i < NUM_SHIPS; i++) begin
            w_nextState[i] = r_state[i];
            w_nextCd[i]    = (r_cdCnt[i] != 8'd0) ? (r_cdCnt[i] - 8'd1) : 8'd0;
            w_nextHold[i]  = r_holdCnt[i];
            w_holdCloak[i] = 1'b0;
            if (r_state[i] == ST_DEAD) begin
                w_nextCd[i]   = 8'd0;
                w_nextHold[i] = 8'd0;
            end else if (i_destroyed[i]) begin
                w_nextState[i] = ST_DEAD;
                w_nextCd[i]    = 8'd0;
                w_nextHold[i]  = 8'd0;
            end else if (w_cloakGrant[i]) begin
                w_nextState[i] = ST_CLOAK;
                w_nextHold[i]  = 8'(CLOAK_HOLD);
            end else if (r_state[i] == ST_CLOAK) begin
                if (w_shieldGrant[i] || !w_cloakEnergyOk[i] || (r_holdCnt[i] <= 8'd1)) begin
                    w_nextState[i] = ST_IDLE;
                    w_nextHold[i]  = 8'd0;
                end else begin
                    w_nextHold[i]  = r_holdCnt[i] - 8'd1;
                    w_holdCloak[i] = 1'b1;
                end
            end else if (w_fireGrant[i]) begin
                w_nextCd[i]    = 8'(FIRE_COOLDOWN);
                w_nextState[i] = (FIRE_COOLDOWN == 0) ? ST_IDLE : ST_COOLDOWN;
            end else if ((r_state[i] == ST_COOLDOWN) && (r_cdCnt[i] <= 8'd1)) begin
                w_nextState[i] = ST_IDLE;
            end
        end
    end

    always_comb begin
        w_countSum = {1'b0, r_fireCount};
        for (int i = 0; i < NUM_SHIPS; i++) begin
            w_countSum = w_countSum + 17'(w_fireGrant[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rrPtr         <= '0;
            r_attemptFire   <= '0;
            r_attemptShield <= '0;
            r_attemptCloak  <= '0;
            r_fireDir       <= '0;
            r_fireCount     <= 16'd0;
            for (int i = 0; i < NUM_SHIPS; i++) begin
                r_state[i]   <= ST_IDLE;
                r_cdCnt[i]   <= 8'd0;
                r_holdCnt[i] <= 8'd0;
            end
        end else begin
            r_rrPtr         <= w_nextPtr;
            r_attemptFire   <= w_fireGrant;
            r_attemptShield <= w_shieldGrant;
            r_attemptCloak  <= w_cloakGrant | w_holdCloak;
            r_fireCount     <= w_countSum[16] ? 16'hFFFF : w_countSum[15:0];
            for (int i = 0; i < NUM_SHIPS; i++) begin
                r_state[i]   <= w_nextState[i];
                r_cdCnt[i]   <= w_nextCd[i];
                r_holdCnt[i] <= w_nextHold[i];
                if (w_fireGrant[i]) begin
                    r_fireDir[2*i +: 2] <= i_fire_dir_req[2*i +: 2];
                end
            end
        end
    end

    assign o_attempt_fire   = r_attemptFire;
    assign o_attempt_shield = r_attemptShield;
    assign o_attempt_cloak  = r_attemptCloak;
    assign o_fire_dir       = r_fireDir;
    assign o_fire_count     = r_fireCount;

endmodule

// File: tb/tb_team_action_scheduler.sv
// Bench for team_action_scheduler: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural reference model.
module tb_team_action_scheduler;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  fireReq, shieldReq, cloakReq, destroyed;
    logic [2*N-1:0] fireDirReq;
    logic [8*N-1:0] energy;
    logic [N-1:0]  attemptFire, attemptShield, attemptCloak;
    logic [2*N-1:0] fireDir;
    logic [15:0]   fireCount;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    team_action_scheduler dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_fire_req       (fireReq),
        .i_fire_dir_req   (fireDirReq),
        .i_shield_req     (shieldReq),
        .i_cloak_req      (cloakReq),
        .i_energy         (energy),
        .i_destroyed      (destroyed),
        .o_attempt_fire   (attemptFire),
        .o_attempt_shield (attemptShield),
        .o_attempt_cloak  (attemptCloak),
        .o_fire_dir       (fireDir),
        .o_fire_count     (fireCount)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  fire, shield, cloak;
        logic [5:0]  dirReq;
        logic [7:0]  en;
        logic [2:0]  expFire, expShield, expCloak;
        logic [5:0]  expDir;
        logic [15:0] expCount;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [2:0] f, s, c, input logic [5:0] d,
                                input logic [7:0] e, input logic [2:0] ef, es, ec,
                                input logic [5:0] ed, input logic [15:0] ecnt);
        vec_t v;
        v.rst = rst; v.fire = f; v.shield = s; v.cloak = c; v.dirReq = d; v.en = e;
        v.expFire = ef; v.expShield = es; v.expCloak = ec; v.expDir = ed; v.expCount = ecnt;
        return v;
    endfunction

    // Behavioural model: per-ship remaining cooldown/cloak cycles, plain round-robin scan.
    bit          mDead  [N];
    int          mCd    [N];
    int          mCloak [N];
    int          mPtr;
    int          mCount;
    logic [2:0]  mFire, mShield, mCloakOut;
    logic [5:0]  mDir;

    task automatic modelStep(input logic rst, input logic [2:0] f, s, c, dest,
                             input logic [5:0] d, input logic [23:0] en);
        bit cand [N];
        int granted;
        int last;
        mFire = '0; mShield = '0; mCloakOut = '0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mDead[i] = 0; mCd[i] = 0; mCloak[i] = 0;
            end
            mPtr = 0; mCount = 0; mDir = '0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            int  e;
            bit  sh, cl, inC;
            e = int'(en[8*i +: 8]);
            cand[i] = 0;
            if (mDead[i]) continue;
            if (dest[i]) begin
                mDead[i] = 1; mCd[i] = 0; mCloak[i] = 0;
                continue;
            end
            sh  = s[i] && (e >= 25);
            inC = mCloak[i] > 0;
            cl  = !inC && c[i] && (e >= 15) && !sh;
            cand[i] = !inC && (mCd[i] == 0) && f[i] && (e >= 40) && !sh && !cl;
            mShield[i] = sh;
            if (cl) begin
                mCloakOut[i] = 1'b1;
                mCloak[i]    = 3;
            end else if (inC && !sh && (e >= 15) && (mCloak[i] > 1)) begin
                mCloakOut[i] = 1'b1;
                mCloak[i]    = mCloak[i] - 1;
            end else begin
                mCloak[i] = 0;
            end
            if (mCd[i] > 0) mCd[i] = mCd[i] - 1;
        end
        granted = 0;
        last    = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mPtr + k) % N;
            if (cand[idx] && granted < 2) begin
                mFire[idx] = 1'b1;
                granted++;
                last = idx;
                mCd[idx] = 2;
                mDir[2*idx +: 2] = d[2*idx +: 2];
            end
        end
        if (granted > 0) mPtr = (last + 1) % N;
        mCount = (mCount + granted > 65535) ? 65535 : mCount + granted;
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] f, s, c, dest,
                                 input logic [5:0] d, input logic [23:0] en);
        @(negedge clk);
        reset = rst; fireReq = f; shieldReq = s; cloakReq = c; destroyed = dest;
        fireDirReq = d; energy = en;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic [2:0] ef, es, ec,
                            input logic [5:0] ed, input logic [15:0] ecnt);
        checkOutput({name, ".fire"},   16'(attemptFire),   16'(ef));
        checkOutput({name, ".shield"}, 16'(attemptShield), 16'(es));
        checkOutput({name, ".cloak"},  16'(attemptCloak),  16'(ec));
        checkOutput({name, ".dir"},    16'(fireDir),       16'(ed));
        checkOutput({name, ".count"},  fireCount,          ecnt);
    endtask

    function automatic logic [7:0] pickEnergy();
        case ($urandom_range(0, 9))
            0: return 8'd14;
            1: return 8'd15;
            2: return 8'd24;
            3: return 8'd25;
            4: return 8'd39;
            5: return 8'd40;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        reset = 1'b1; fireReq = '0; shieldReq = '0; cloakReq = '0; destroyed = '0;
        fireDirReq = '0; energy = '0;

        // Directed table: each row is one cycle of inputs and the outputs expected after it.
        vecs.push_back(mk(1, 0, 0, 0, 6'b000000,   0, 0, 0, 0, 6'b000000,  0));
        vecs.push_back(mk(0, 3'b111, 0, 0, 6'b011100, 100, 3'b011, 0, 0, 6'b001100,  2));
        vecs.push_back(mk(0, 3'b111, 0, 0, 6'b011100, 100, 3'b100, 0, 0, 6'b011100,  3));
        vecs.push_back(mk(0, 3'b111, 0, 0, 6'b011100, 100, 3'b000, 0, 0, 6'b011100,  3));
        vecs.push_back(mk(0, 3'b111, 0, 0, 6'b011100, 100, 3'b011, 0, 0, 6'b011100,  5));
        vecs.push_back(mk(0, 3'b111, 0, 0, 6'b011100, 100, 3'b100, 0, 0, 6'b011100,  6));
        vecs.push_back(mk(0, 0, 0, 0, 6'b011100, 100, 0, 0, 0, 6'b011100,  6));
        vecs.push_back(mk(0, 0, 0, 0, 6'b011100, 100, 0, 0, 0, 6'b011100,  6));
        vecs.push_back(mk(0, 3'b111, 0, 0, 6'b011100, 100, 3'b011, 0, 0, 6'b011100,  8));
        vecs.push_back(mk(0, 0, 0, 0, 6'b011100, 100, 0, 0, 0, 6'b011100,  8));
        vecs.push_back(mk(0, 0, 0, 0, 6'b011100, 100, 0, 0, 0, 6'b011100,  8));
        vecs.push_back(mk(0, 3'b111, 0, 0, 6'b101101, 100, 3'b101, 0, 0, 6'b101101, 10));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000, 100, 0, 0, 0, 6'b101101, 10));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000, 100, 0, 0, 0, 6'b101101, 10));
        vecs.push_back(mk(0, 3'b001, 0, 0, 6'b000010,  40, 3'b001, 0, 0, 6'b101110, 11));
        vecs.push_back(mk(0, 3'b001, 0, 0, 6'b000010,  40, 3'b000, 0, 0, 6'b101110, 11));
        vecs.push_back(mk(0, 3'b001, 0, 0, 6'b000010,  40, 3'b000, 0, 0, 6'b101110, 11));
        vecs.push_back(mk(0, 3'b001, 0, 0, 6'b000010,  40, 3'b001, 0, 0, 6'b101110, 12));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000,  40, 0, 0, 0, 6'b101110, 12));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000,  40, 0, 0, 0, 6'b101110, 12));
        vecs.push_back(mk(0, 3'b010, 3'b010, 3'b010, 6'b000000, 30, 0, 3'b010, 0, 6'b101110, 12));
        vecs.push_back(mk(0, 3'b010, 0, 0, 6'b000000,  39, 0, 0, 0, 6'b101110, 12));
        vecs.push_back(mk(0, 3'b010, 0, 0, 6'b000100,  40, 3'b010, 0, 0, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 3'b001, 0, 6'b000000,  24, 0, 0, 0, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 3'b001, 0, 6'b000000,  25, 0, 3'b001, 0, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 3'b100, 6'b000000,  50, 0, 0, 3'b100, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000,  50, 0, 0, 3'b100, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000,  50, 0, 0, 3'b100, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000,  50, 0, 0, 0, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 3'b100, 6'b000000,  50, 0, 0, 3'b100, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000,  50, 0, 0, 3'b100, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000,  14, 0, 0, 0, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000,  50, 0, 0, 0, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 3'b100, 6'b000000,  14, 0, 0, 0, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 3'b100, 6'b000000,  15, 0, 0, 3'b100, 6'b100110, 13));
        vecs.push_back(mk(0, 3'b100, 0, 3'b100, 6'b000000, 100, 0, 0, 3'b100, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 3'b100, 0, 6'b000000, 100, 0, 3'b100, 0, 6'b100110, 13));
        vecs.push_back(mk(0, 0, 0, 0, 6'b000000, 100, 0, 0, 0, 6'b100110, 13));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].fire, vecs[i].shield, vecs[i].cloak, 3'b000,
                          vecs[i].dirReq, {3{vecs[i].en}});
            @(posedge clk); #1;
            checkAll($sformatf("vec%0d", i), vecs[i].expFire, vecs[i].expShield,
                     vecs[i].expCloak, vecs[i].expDir, vecs[i].expCount);
        end

        // Destroyed mid-cooldown: ship0 silent from then on until reset.
        applyStimulus(0, 3'b001, 0, 0, 3'b000, 6'b000011, {3{8'd40}});
        @(posedge clk); #1;
        checkAll("dead.fire", 3'b001, 0, 0, 6'b100111, 14);
        applyStimulus(0, 0, 3'b001, 0, 3'b001, 6'b000000, {3{8'd100}});
        @(posedge clk); #1;
        checkAll("dead.hit", 0, 0, 0, 6'b100111, 14);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 3'b001, 3'b001, 3'b001, 3'b000, 6'b000001, {3{8'd100}});
            @(posedge clk); #1;
            checkAll($sformatf("dead.sticky%0d", k), 0, 0, 0, 6'b100111, 14);
        end
        applyStimulus(1, 3'b001, 3'b001, 3'b001, 3'b000, 6'b000001, {3{8'd100}});
        @(posedge clk); #1;
        checkAll("dead.reset", 0, 0, 0, 6'b000000, 0);
        applyStimulus(0, 3'b001, 0, 0, 3'b000, 6'b000001, {3{8'd40}});
        @(posedge clk); #1;
        checkAll("dead.revive", 3'b001, 0, 0, 6'b000001, 1);

        // Saturation of the fire counter.
        applyStimulus(1, 0, 0, 0, 3'b000, 6'b000000, {3{8'd100}});
        @(posedge clk); #1;
        checkAll("sat.reset", 0, 0, 0, 6'b000000, 0);
        applyStimulus(0, 3'b111, 0, 0, 3'b000, 6'b000000, {3{8'd100}});
        dut.r_fireCount = 16'hFFFE;
        @(posedge clk); #1;
        checkAll("sat.two", 3'b011, 0, 0, 6'b000000, 16'hFFFF);
        applyStimulus(0, 3'b111, 0, 0, 3'b000, 6'b000000, {3{8'd100}});
        @(posedge clk); #1;
        checkAll("sat.hold", 3'b100, 0, 0, 6'b000000, 16'hFFFF);

        // Randomized traffic against the reference model, with periodic resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        rst;
            logic [2:0]  f, s, c, dest;
            logic [5:0]  d;
            logic [23:0] en;
            rst  = (cyc % 250 == 0);
            f    = 3'($urandom_range(0, 7));
            s    = 3'($urandom & $urandom & $urandom);
            c    = 3'($urandom & $urandom);
            d    = 6'($urandom_range(0, 63));
            en   = {pickEnergy(), pickEnergy(), pickEnergy()};
            dest = ($urandom_range(0, 199) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            applyStimulus(rst, f, s, c, dest, d, en);
            modelStep(rst, f, s, c, dest, d, en);
            @(posedge clk); #1;
            checkAll($sformatf("rand%0d", cyc), mFire, mShield, mCloakOut, mDir, 16'(mCount));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
